// File: rtl/peak_tracker_pkg.sv
// +----------------------------------------------------------------------------+
// | peak_tracker_pkg : state encoding and default constants for peak_tracker   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package peak_tracker_pkg;

  localparam int c_dw_def      = 12;
  localparam int c_pw_def      = 32;
  localparam int c_pos_rst_def = 500;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/peak_cmp.sv
// +----------------------------------------------------------------------------+
// | peak_cmp : accepts a sample that beats best + HYST, or any first sample    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module peak_cmp
  import peak_tracker_pkg::*;
#(
  parameter int DW   = c_dw_def,
  parameter int HYST = 0
) (
  input  logic [DW-1:0] smp_value,
  input  logic [DW-1:0] best_value,
  input  logic          first,
  output logic          accept
);

  localparam logic [DW:0] c_hyst = (DW+1)'(HYST);

  logic [DW:0] w_thresh;

  // A threshold above 2^DW-1 can never be exceeded by a DW-bit sample,
  // so an overflowing sum rejects without a separate test.
  assign w_thresh = {1'b0, best_value} + c_hyst;
  assign accept   = first | ({1'b0, smp_value} > w_thresh);

endmodule

`default_nettype wire

// File: rtl/peak_tracker.sv
// +----------------------------------------------------------------------------+
// | peak_tracker : sweep controller tracking the largest sample and positions  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module peak_tracker
  import peak_tracker_pkg::*;
#(
  parameter int DW      = c_dw_def,
  parameter int N_CH    = 2,
  parameter int PW      = c_pw_def,
  parameter int POS_RST = c_pos_rst_def,
  parameter int HYST    = 0,
  parameter int N_SMP   = 256
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic               smp_valid,
  input  logic [DW-1:0]      smp_value,
  input  logic [N_CH*PW-1:0] pos,
  output logic [DW-1:0]      best_value,
  output logic [N_CH*PW-1:0] best_pos,
  output logic               new_max,
  output logic               busy,
  output logic               done,
  output logic [15:0]        upd_cnt
);

  localparam logic [15:0] c_last_idx = 16'(N_SMP - 1);

  state_e              state_q, state_d;
  logic [DW-1:0]       best_value_q, best_value_d;
  logic [N_CH*PW-1:0]  best_pos_q, best_pos_d;
  logic [15:0]         upd_cnt_q, upd_cnt_d;
  logic [15:0]         smp_cnt_q, smp_cnt_d;
  logic                new_max_q, new_max_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [N_CH*PW-1:0]  w_pos_rst;
  logic                w_eval;
  logic                w_accept;

  for (genvar k = 0; k < N_CH; k++) begin : g_pos_rst
    assign w_pos_rst[k*PW +: PW] = PW'(POS_RST);
  end

  // A sample arriving with start belongs to neither the old nor the new sweep.
  assign w_eval = (state_q == ST_SWEEP) && smp_valid && !start;

  peak_cmp #(
    .DW   (DW),
    .HYST (HYST)
  ) u_cmp (
    .smp_value  (smp_value),
    .best_value (best_value_q),
    .first      (smp_cnt_q == 16'd0),
    .accept     (w_accept)
  );

  always_comb begin
    state_d      = state_q;
    best_value_d = best_value_q;
    best_pos_d   = best_pos_q;
    upd_cnt_d    = upd_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    new_max_d    = 1'b0;

    if (w_eval) begin
      smp_cnt_d = smp_cnt_q + 16'd1;
      if (w_accept) begin
        best_value_d = smp_value;
        best_pos_d   = pos;
        new_max_d    = 1'b1;
        if (upd_cnt_q != 16'hFFFF) begin
          upd_cnt_d = upd_cnt_q + 16'd1;
        end
      end
    end

    if (state_q == ST_SWEEP && abort) begin
      state_d = ST_IDLE;
    end else if (start && !abort) begin
      state_d      = ST_SWEEP;
      best_value_d = '0;
      best_pos_d   = w_pos_rst;
      upd_cnt_d    = '0;
      smp_cnt_d    = '0;
    end else if (state_q == ST_SWEEP) begin
      if (w_eval && smp_cnt_q == c_last_idx) begin
        state_d = ST_DONE;
      end
    end else begin
      state_d = ST_IDLE;
    end

    busy_d = (state_d == ST_SWEEP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      best_value_q <= '0;
      best_pos_q   <= w_pos_rst;
      upd_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      new_max_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      best_value_q <= best_value_d;
      best_pos_q   <= best_pos_d;
      upd_cnt_q    <= upd_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      new_max_q    <= new_max_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign best_value = best_value_q;
  assign best_pos   = best_pos_q;
  assign upd_cnt    = upd_cnt_q;
  assign new_max    = new_max_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire
